// File: rtl/sprite_renderer_if.sv
// Pixel bus to the 160x120 VGA adapter together with the sprite ROM read port.
interface sprite_renderer_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [6:0] romAddr;
  logic [2:0] romData;

  modport master (output x, y, colour, plot, romAddr, input romData);
  modport slave  (input x, y, colour, plot, romAddr, output romData);
endinterface

// File: rtl/sprite_renderer.sv
// Erases the sprite box at its last position and redraws it at the newly
// sampled position, one pixel per clock through a 2-stage pipeline.
module sprite_renderer #(
  parameter int unsigned SPR_W     = 10,
  parameter int unsigned SPR_H     = 11,
  parameter int unsigned SCR_W     = 160,
  parameter int unsigned SCR_H     = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000,
  parameter logic [2:0]  TRANSP    = 3'b111
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic [7:0]        posX,
  input  logic [6:0]        posY,
  input  logic              frameTick,
  output logic              busy,
  output logic              frameDone,
  sprite_renderer_if.master pix
);

  localparam int unsigned CW = $clog2(SPR_W);
  localparam int unsigned RW = $clog2(SPR_H);

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_ERASE, S_DRAW, S_DRAIN} state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_old_x, r_new_x;
  logic [6:0]      r_old_y, r_new_y;
  logic            r_old_valid, r_pending, r_drain, r_busy, r_frame_done;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_s1_valid, r_s1_draw;
  logic [8:0]      r_s1_x;
  logic [7:0]      r_s1_y;
  logic [7:0]      r_x;
  logic [6:0]      r_y;
  logic [2:0]      r_colour;
  logic            r_plot;

  logic            w_capture, w_cnt_clr, w_cnt_step, w_commit, w_pend_clr;
  logic            w_pix_valid, w_pix_draw;
  logic            w_last_col, w_last_row;
  logic [8:0]      w_pix_x;
  logic [7:0]      w_pix_y;
  logic [6:0]      w_row7;

  assign w_last_col = (r_col == CW'(SPR_W - 1));
  assign w_last_row = (r_row == RW'(SPR_H - 1));
  assign w_row7     = 7'(r_row);

  // Sprite ROM address straight from the counters
  assign pix.romAddr = w_row7 * 7'(SPR_W) + 7'(r_col);

  // Current pixel coordinate, widened so wrap past 255/127 reads as off-screen
  assign w_pix_x = {1'b0, (w_pix_draw ? r_new_x : r_old_x)} + 9'(r_col);
  assign w_pix_y = {1'b0, (w_pix_draw ? r_new_y : r_old_y)} + 8'(r_row);

  assign pix.x      = r_x;
  assign pix.y      = r_y;
  assign pix.colour = r_colour;
  assign pix.plot   = r_plot;
  assign busy       = r_busy;
  assign frameDone  = r_frame_done;

  // FSM state register
  always_ff @(posedge Clk) begin
    if (!ResetN) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state and per-state control strobes
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_step   = 1'b0;
    w_commit     = 1'b0;
    w_pend_clr   = 1'b0;
    w_pix_valid  = 1'b0;
    w_pix_draw   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frameTick || r_pending) begin
          w_pend_clr = 1'b1;
          if (!r_old_valid || (posX != r_old_x) || (posY != r_old_y))
            w_state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_capture    = 1'b1;
        w_cnt_clr    = 1'b1;
        w_state_next = r_old_valid ? S_ERASE : S_DRAW;
      end
      S_ERASE: begin
        w_pix_valid = 1'b1;
        w_cnt_step  = 1'b1;
        if (w_last_col && w_last_row) begin
          w_cnt_clr    = 1'b1;
          w_state_next = S_DRAW;
        end
      end
      S_DRAW: begin
        w_pix_valid = 1'b1;
        w_pix_draw  = 1'b1;
        w_cnt_step  = 1'b1;
        if (w_last_col && w_last_row) begin
          w_cnt_clr    = 1'b1;
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain) begin
          w_commit     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Position bookkeeping, tick pending flag, busy and frameDone
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_old_x      <= '0;
      r_old_y      <= '0;
      r_new_x      <= '0;
      r_new_y      <= '0;
      r_old_valid  <= 1'b0;
      r_pending    <= 1'b0;
      r_drain      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_capture) begin
        r_new_x <= posX;
        r_new_y <= posY;
      end
      if (w_commit) begin
        r_old_x     <= r_new_x;
        r_old_y     <= r_new_y;
        r_old_valid <= 1'b1;
      end
      if (frameTick && (r_state != S_IDLE)) r_pending <= 1'b1;
      else if (w_pend_clr)                  r_pending <= 1'b0;
      r_drain      <= (r_state == S_DRAIN) && !r_drain;
      r_busy       <= (w_state_next != S_IDLE);
      r_frame_done <= (r_state == S_DRAIN) && !r_drain;
    end
  end

  // Column/row scan counters, column fastest
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_cnt_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_cnt_step) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Stage 1: coordinates captured alongside the ROM read
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_s1_valid <= 1'b0;
      r_s1_draw  <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
    end else begin
      r_s1_valid <= w_pix_valid;
      r_s1_draw  <= w_pix_draw;
      if (w_pix_valid) begin
        r_s1_x <= w_pix_x;
        r_s1_y <= w_pix_y;
      end
    end
  end

  // Stage 2: pixel outputs with clip and transparency gating on plot
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
    end else if (r_s1_valid) begin
      r_x      <= r_s1_x[7:0];
      r_y      <= r_s1_y[6:0];
      r_colour <= r_s1_draw ? pix.romData : BG_COLOUR;
      r_plot   <= (r_s1_x < 9'(SCR_W)) && (r_s1_y < 8'(SCR_H)) &&
                  !(r_s1_draw && (pix.romData == TRANSP));
    end else begin
      r_plot   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: table of frames plus pending and reset sequences.
module tb_sprite_renderer;

  logic       Clk = 1'b0;
  logic       ResetN;
  logic [7:0] posX;
  logic [6:0] posY;
  logic       frameTick;
  logic       busy;
  logic       frameDone;

  sprite_renderer_if pix();

  sprite_renderer dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .posX      (posX),
    .posY      (posY),
    .frameTick (frameTick),
    .busy      (busy),
    .frameDone (frameDone),
    .pix       (pix)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM model
  logic [2:0] rom_mem [0:127];
  always @(posedge Clk) pix.romData <= rom_mem[pix.romAddr];

  typedef struct {
    int px; int py; int rom_mode; int exp_col;
    int busy_n; int done_at; int erase_n; int draw_n;
    int fe; int le; int fd; int ld;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Per-window statistics; xy values encoded as x*1000+y
  int cyc, busy_n, first_busy, done_cnt, done_at, erase_n, draw_n;
  int fe, le, fd, ld, ld1, clip_bad, bad_col, busy_rises, gap_low, plots;
  int exp_col;
  logic seen_busy, prev_busy;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; busy_n = 0; first_busy = 0; done_cnt = 0; done_at = -1;
    erase_n = 0; draw_n = 0; fe = -1; le = -1; fd = -1; ld = -1; ld1 = -1;
    clip_bad = 0; bad_col = 0; busy_rises = 0; gap_low = 0; plots = 0;
    seen_busy = 1'b0; prev_busy = 1'b0;
  endtask

  task automatic set_rom(input int mode);
    for (int i = 0; i < 128; i++)
      rom_mem[i] = (mode == 0) ? 3'b010 : ((i == 0) ? 3'b111 : 3'b100);
  endtask

  // One clock: sample outputs at the falling edge and accumulate statistics
  task automatic step();
    int xy;
    @(negedge Clk);
    cyc++;
    if (busy) busy_n++;
    if (busy && !seen_busy) begin seen_busy = 1'b1; first_busy = cyc; end
    if (busy && !prev_busy) busy_rises++;
    if (!busy && done_cnt >= 1 && busy_rises == 1) gap_low++;
    if (pix.plot) begin
      plots++;
      xy = int'(pix.x) * 1000 + int'(pix.y);
      if (int'(pix.x) >= 160 || int'(pix.y) >= 120) clip_bad++;
      if (pix.colour == 3'b000) begin
        erase_n++;
        if (fe < 0) fe = xy;
        le = xy;
      end else begin
        draw_n++;
        if (fd < 0) fd = xy;
        ld = xy;
        if (int'(pix.colour) != exp_col) bad_col++;
      end
    end
    if (frameDone) begin
      if (done_cnt == 0) begin done_at = cyc - first_busy; ld1 = ld; end
      done_cnt++;
    end
    prev_busy = busy;
  endtask

  task automatic pulse_tick();
    frameTick = 1'b1;
    step();
    frameTick = 1'b0;
  endtask

  // Tick once and run until the frame ends (or clearly never starts)
  task automatic run_frame();
    clear_stats();
    pulse_tick();
    while (1) begin
      if (seen_busy && !busy) break;
      if (!seen_busy && cyc >= 8) break;
      if (cyc >= 600) begin
        checks++; failures++;
        $display("FAIL frame_timeout actual=busy_after_%0d_cycles expected=idle", cyc);
        break;
      end
      step();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_x"},         int'(pix.x),       0);
    check({tag, "_y"},         int'(pix.y),       0);
    check({tag, "_colour"},    int'(pix.colour),  0);
    check({tag, "_plot"},      int'(pix.plot),    0);
    check({tag, "_busy"},      int'(busy),        0);
    check({tag, "_frameDone"}, int'(frameDone),   0);
    check({tag, "_romAddr"},   int'(pix.romAddr), 0);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{0,   109, 0, 2, 113, 112,   0, 110,     -1,     -1,    109,   9119};
    vecs[1] = '{1,   109, 0, 2, 223, 222, 110, 110,    109,   9119,   1109,  10119};
    vecs[2] = '{155, 115, 1, 4, 223, 222, 110,  24,   1109,  10119, 156115, 159119};
    vecs[3] = '{5,    20, 0, 2, 223, 222,  25, 110, 155115, 159119,   5020,  14030};
    vecs[4] = '{5,    20, 0, 2,   0,  -1,   0,   0,     -1,     -1,     -1,     -1};

    set_rom(0);
    exp_col = 2;
    posX = 8'd0; posY = 7'd0;
    ResetN = 1'b0; frameTick = 1'b1;
    clear_stats();
    for (int i = 0; i < 3; i++) step();
    check("reset_plots", plots, 0);
    check_outputs_zero("reset");
    ResetN = 1'b1; frameTick = 1'b0;
    step(); step();

    for (int v = 0; v < 5; v++) begin
      posX = 8'(vecs[v].px);
      posY = 7'(vecs[v].py);
      set_rom(vecs[v].rom_mode);
      exp_col = vecs[v].exp_col;
      run_frame();
      check($sformatf("v%0d_busy_cycles", v), busy_n,   vecs[v].busy_n);
      check($sformatf("v%0d_done_cnt", v),    done_cnt, (vecs[v].busy_n > 0) ? 1 : 0);
      check($sformatf("v%0d_done_at", v),     done_at,  vecs[v].done_at);
      check($sformatf("v%0d_erase_plots", v), erase_n,  vecs[v].erase_n);
      check($sformatf("v%0d_draw_plots", v),  draw_n,   vecs[v].draw_n);
      check($sformatf("v%0d_first_erase", v), fe,       vecs[v].fe);
      check($sformatf("v%0d_last_erase", v),  le,       vecs[v].le);
      check($sformatf("v%0d_first_draw", v),  fd,       vecs[v].fd);
      check($sformatf("v%0d_last_draw", v),   ld,       vecs[v].ld);
      check($sformatf("v%0d_clipped", v),     clip_bad, 0);
      check($sformatf("v%0d_bad_colour", v),  bad_col,  0);
      step(); step();
    end

    // Ticks during DRAW: pos change must wait for the next frame, one extra redraw follows
    posX = 8'd1; posY = 7'd109;
    set_rom(0);
    exp_col = 2;
    clear_stats();
    pulse_tick();
    while (cyc < 115) step();
    posX = 8'd3;
    pulse_tick();
    for (int i = 0; i < 5; i++) step();
    pulse_tick();
    while (cyc < 560) step();
    check("pend_done_cnt",    done_cnt,   2);
    check("pend_busy_rises",  busy_rises, 2);
    check("pend_idle_gap",    gap_low,    1);
    check("pend_busy_cycles", busy_n,     446);
    check("pend_erase_plots", erase_n,    220);
    check("pend_draw_plots",  draw_n,     220);
    check("pend_frame1_last", ld1,        10119);
    check("pend_first_draw",  fd,         1109);
    check("pend_last_draw",   ld,         12119);
    check("pend_first_erase", fe,         5020);

    // Reset during ERASE abandons the frame; next tick draws without erase
    posX = 8'd40; posY = 7'd50;
    clear_stats();
    pulse_tick();
    while (cyc < 50) step();
    check("pre_reset_busy", int'(busy), 1);
    ResetN = 1'b0;
    step();
    check_outputs_zero("midreset");
    ResetN = 1'b1;
    step();
    run_frame();
    check("post_reset_busy_cycles", busy_n,  113);
    check("post_reset_erase_plots", erase_n, 0);
    check("post_reset_draw_plots",  draw_n,  110);
    check("post_reset_first_draw",  fd,      40050);
    check("post_reset_last_draw",   ld,      49060);
    check("post_reset_done_at",     done_at, 112);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Downstream consumer of the character-movement stage. Samples the character's top-left position (`posX`, `posY`) on each animation tick, erases the sprite box at the previously drawn position with the background colour, then redraws the sprite at the new position from a synchronous sprite ROM. It emits one pixel per clock (`x`, `y`, `colour`, `plot`) to the 160x120 VGA adapter.

## Interface
- `SPR_W`, 10: sprite width in pixels.
- `SPR_H`, 11: sprite height in pixels.
- `SCR_W`, 160: screen width; pixels with x >= SCR_W are clipped.
- `SCR_H`, 120: screen height; pixels with y >= SCR_H are clipped.
- `BG_COLOUR`, 3'b000: erase colour.
- `TRANSP`, 3'b111: ROM colour code treated as transparent.
- `Clk`  in  1  system clock.
- `ResetN`  in  1  reset, synchronous, active-low.
- `posX`  in  8  character X from the movement stage.
- `posY`  in  7  character Y from the movement stage.
- `frameTick`  in  1  one-cycle animation enable (16 Hz).
- `romAddr`  out  7  sprite ROM address, row*SPR_W+col; combinational from the counters.
- `romData`  in  3  ROM colour, valid one clock after `romAddr`.
- `x`  out  8  pixel X (registered).
- `y`  out  7  pixel Y (registered).
- `colour`  out  3  pixel colour (registered).
- `plot`  out  1  VGA write strobe (registered).
- `busy`  out  1  high in every state except IDLE.
- `frameDone`  out  1  one-cycle pulse when a redraw completes.

## Operation
- **State registers:**
  - `oldX`/`oldY`: last drawn position.
  - `oldValid`: a sprite is on screen.
  - `newX`/`newY`: latched target position.
  - `col` (0..SPR_W-1), `row` (0..SPR_H-1).
  - `pending`: 1 bit.
  - 2-stage pixel pipeline.
- **FSM: IDLE -> CAPTURE -> ERASE -> DRAW -> DRAIN -> IDLE.**
  - IDLE, on `frameTick` or `pending`:
    - If `!oldValid`, or (`posX`,`posY`) differs from (`oldX`,`oldY`): go to CAPTURE and clear `pending`.
    - Otherwise stay in IDLE, clear `pending`, and do not pulse `frameDone`.
  - CAPTURE (1 cycle): `newX<=posX`, `newY<=posY`, `col<=0`, `row<=0`. Next state is ERASE if `oldValid`, otherwise DRAW.
  - ERASE: one pixel per cycle, col fastest. Pixel is (`oldX+col`, `oldY+row`) with colour `BG_COLOUR`. After (SPR_W-1, SPR_H-1): reset the counters and go to DRAW.
  - DRAW: one pixel per cycle. `romAddr=row*SPR_W+col`; pixel is (`newX+col`, `newY+row`) with colour `romData`. After the last pixel go to DRAIN.
  - DRAIN (2 cycles): flush the pipeline. On exit: `oldX<=newX`, `oldY<=newY`, `oldValid<=1`, pulse `frameDone`, go to IDLE.
- **`frameTick` while `busy`:** sets `pending`. Only one is held; further ticks are absorbed. Position is re-sampled in IDLE, never mid-draw. `posX`/`posY` changes while busy never affect the frame in progress.
- **Plot gating:** `plot=1` only for ERASE/DRAW pipeline entries where:
  - pixel x < SCR_W and y < SCR_H; sums are computed at 9/8 bits so wrap past 255/127 counts as clipped;
  - and, in DRAW only, `romData != TRANSP`.
- **Clipped or transparent pixels:** `plot=0`, but `x`/`y`/`colour` still update.
- **Outputs outside active pixels:** hold their last values with `plot=0`.
- **Reset outputs:** `x=0`, `y=0`, `colour=0`, `plot=0`, `busy=0`, `frameDone=0`, `romAddr=0`.
- **Reset internal state:** `oldValid=0`, `pending=0`, FSM=IDLE.
- **Reset mid-operation:** abandons the frame immediately and clears `oldValid`. The next tick draws without erase; erasing the stale pixels is the screen-clear logic's job.

## Timing
- Pixel pipeline latency is 2 cycles. The counter value at cycle n is plotted at cycle n+2, for both erase and draw.
- DRAW stage 1 registers the coords alongside the ROM read. Stage 2 registers `x`/`y`/`colour`/`plot`.
- Tick sampled at edge t:
  - CAPTURE in cycle t+1.
  - ERASE: 110 cycles (defaults).
  - DRAW: 110 cycles.
  - DRAIN: 2 cycles.
- Busy length: full redraw is 223 cycles; first draw with no erase is 113 cycles. `busy` rises the cycle after the sampling edge.
- `frameDone` is high in the last DRAIN cycle. `busy` falls on the following cycle.
- 223 cycles is far below the tick period (~3.1M cycles at 50 MHz), so `pending` exercises only in test.

## Test plan
- **Reset:** hold `ResetN=0` 3 cycles with `frameTick=1` -> all outputs 0, `busy=0`, no plots.
- **First draw:** pos (0,109), ROM all 3'b010, one tick -> no erase, exactly 110 plots. First plot x=0,y=109; last x=9,y=119. `frameDone` 112 cycles after CAPTURE.
- **Move right:** pos (1,109) after the first draw -> 110 `BG_COLOUR` plots over x 0..9, then 110 sprite plots over x 1..10. Afterwards `oldX=1`.
- **No move:** tick with pos unchanged -> `busy` stays 0, no plots, no `frameDone`.
- **Clip and transparency:** pos (155,115), ROM entry 0 = `TRANSP`, rest 3'b100 -> 24 plots in DRAW (5x5 on-screen minus 1), none with x>=160 or y>=120.
- **Tick while busy / reset mid-draw:**
  - Second tick during DRAW with pos changed to (3,109) -> a second redraw starts immediately after `frameDone`.
  - `ResetN=0` mid-ERASE -> outputs 0 next cycle; the following tick draws with no erase.
